// File: rtl/mycpu_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: EX/MEM/WB destination
// scoreboard driving operand forwarding, load-use stall and memory freeze.
module mycpu_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [4:0]       id_dst,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             mem_busy,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             allow_in,
  output logic             ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       wen;
    logic       is_load;
  } sb_entry_t;

  sb_entry_t ex_q, mem_q, wb_q;
  sb_entry_t ex_d, mem_d, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic load_use;

  function automatic logic live(input sb_entry_t e);
    return e.valid && e.wen && (e.dst != '0);
  endfunction

  // Youngest live producer wins; a load still in EX cannot forward yet.
  function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] r);
    if (!used || r == '0) return 2'd0;
    if (live(ex_q) && ex_q.dst == r) return ex_q.is_load ? 2'd0 : 2'd1;
    if (live(mem_q) && mem_q.dst == r) return 2'd2;
    if (live(wb_q) && wb_q.dst == r) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic ld_hit(input logic used, input logic [4:0] r);
    return used && (r != '0) && live(ex_q) && ex_q.is_load && (ex_q.dst == r);
  endfunction

  always_comb begin
    fwd_a_sel   = fwd_sel(id_rs_used, id_rs);
    fwd_b_sel   = fwd_sel(id_rt_used, id_rt);
    load_use    = id_valid && (ld_hit(id_rs_used, id_rs) || ld_hit(id_rt_used, id_rt));
    pipe_freeze = mem_busy;
    ex_bubble   = load_use && !mem_busy;
    allow_in    = !(load_use || mem_busy);
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!pipe_freeze) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (ex_bubble) ex_d = '0;
      else           ex_d = '{valid: id_valid, dst: id_dst, wen: id_wen, is_load: id_is_load};
    end
    stall_cnt_d = stall_cnt_q;
    if (!allow_in && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mycpu_hazard_ctrl.sv
// Directed bench for mycpu_hazard_ctrl with an in-flight instruction model.
module tb_mycpu_hazard_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_rs_used, id_rt_used, id_wen, id_is_load, mem_busy;
  logic [4:0] id_rs, id_rt, id_dst;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic allow_in, ex_bubble, pipe_freeze;
  logic [CW-1:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  mycpu_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst),
    .id_wen(id_wen), .id_is_load(id_is_load), .mem_busy(mem_busy),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .allow_in(allow_in),
    .ex_bubble(ex_bubble), .pipe_freeze(pipe_freeze), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Model: in-flight instructions by age (0 = one ahead of ID, i.e. in EX).
  typedef struct {
    bit       v;
    bit [4:0] d;
    bit       w;
    bit       l;
  } inst_t;
  inst_t fl[3];
  inst_t nfl[3];
  int    mcnt, ncnt;
  bit    chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_sel(input bit used, input bit [4:0] r);
    if (!used || r == 0) return 0;
    for (int unsigned i = 0; i < 3; i++)
      if (fl[i].v && fl[i].w && fl[i].d != 0 && fl[i].d == r)
        return (i == 0 && fl[i].l) ? 0 : int'(i) + 1;
    return 0;
  endfunction

  function automatic bit m_hz(input bit used, input bit [4:0] r);
    return used && r != 0 && fl[0].v && fl[0].w && fl[0].l && fl[0].d == r;
  endfunction

  task automatic m_clear();
    for (int unsigned i = 0; i < 3; i++) fl[i] = '{0, 0, 0, 0};
    mcnt = 0;
  endtask

  always @(posedge rst) m_clear();

  always @(posedge clk) begin
    if (rst) m_clear();
    else begin
      fl   = nfl;
      mcnt = ncnt;
    end
  end

  always @(negedge clk) begin
    bit hz, bub, alw;
    hz  = id_valid && (m_hz(id_rs_used, id_rs) || m_hz(id_rt_used, id_rt));
    bub = hz && !mem_busy;
    alw = !(hz || mem_busy);
    if (chk_en) begin
      check("fwd_a_sel", fwd_a_sel, m_sel(id_rs_used, id_rs));
      check("fwd_b_sel", fwd_b_sel, m_sel(id_rt_used, id_rt));
      check("allow_in", allow_in, alw);
      check("ex_bubble", ex_bubble, bub);
      check("pipe_freeze", pipe_freeze, mem_busy);
      check("stall_cnt", stall_cnt, mcnt);
    end
    nfl = fl;
    if (!mem_busy) begin
      nfl[2] = fl[1];
      nfl[1] = fl[0];
      nfl[0] = bub ? '{0, 0, 0, 0} : '{id_valid, id_dst, id_wen, id_is_load};
    end
    ncnt = (!alw && mcnt < (1 << CW) - 1) ? mcnt + 1 : mcnt;
  end

  // One ID-stage cycle: inputs settle after posedge, outputs observed after negedge.
  task automatic cyc(input bit v, input bit [4:0] rs, input bit rsu, input bit [4:0] rt,
                     input bit rtu, input bit [4:0] dst, input bit w, input bit ld,
                     input bit busy);
    @(posedge clk); #1;
    id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
    id_dst = dst; id_wen = w; id_is_load = ld; mem_busy = busy;
    @(negedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_dst = 0; id_wen = 0; id_is_load = 0; mem_busy = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    do_reset();
    chk_en = 1'b1;
    @(negedge clk); #1;
    check("rst_fwd_a", fwd_a_sel, 0);
    check("rst_allow", allow_in, 1);
    check("rst_bubble", ex_bubble, 0);
    check("rst_cnt", stall_cnt, 0);

    // EX forwarding
    cyc(1, 1, 1, 2, 1, 3, 1, 0, 0);
    cyc(1, 3, 1, 3, 1, 4, 1, 0, 0);
    check("ex_fwd_a", fwd_a_sel, 1);
    check("ex_fwd_b", fwd_b_sel, 1);
    check("ex_allow", allow_in, 1);

    // MEM / WB forwarding
    cyc(1, 0, 0, 0, 0, 6, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 5, 1, 6, 1, 1, 1, 0, 0);
    check("mem_fwd_a", fwd_a_sel, 2);
    check("wb_fwd_b", fwd_b_sel, 3);

    // youngest match wins
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
    cyc(1, 7, 1, 0, 0, 2, 1, 0, 0);
    check("young_fwd_a", fwd_a_sel, 1);

    // load-use
    cyc(1, 0, 0, 0, 0, 8, 1, 1, 0);
    cyc(1, 8, 1, 0, 1, 9, 1, 0, 0);
    check("lu_allow", allow_in, 0);
    check("lu_bubble", ex_bubble, 1);
    check("lu_fwd_a", fwd_a_sel, 0);
    cyc(1, 8, 1, 0, 1, 9, 1, 0, 0);
    check("lu_cnt", stall_cnt, 1);
    check("lu_fwd_a2", fwd_a_sel, 2);
    check("lu_allow2", allow_in, 1);

    // $0 and unused operand
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0);
    cyc(1, 0, 1, 0, 1, 3, 1, 0, 0);
    check("z_allow", allow_in, 1);
    check("z_fwd_a", fwd_a_sel, 0);
    cyc(1, 0, 0, 0, 0, 10, 1, 1, 0);
    cyc(1, 11, 1, 10, 0, 3, 1, 0, 0);
    check("unused_allow", allow_in, 1);
    check("unused_fwd_b", fwd_b_sel, 0);

    // freeze dominates load-use
    do_reset();
    cyc(1, 0, 0, 0, 0, 12, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 12, 1, 0, 0, 13, 1, 0, 1);
      check("frz_bubble", ex_bubble, 0);
      check("frz_allow", allow_in, 0);
    end
    cyc(1, 12, 1, 0, 0, 13, 1, 0, 0);
    check("frz_lu_bubble", ex_bubble, 1);
    cyc(1, 12, 1, 0, 0, 13, 1, 0, 0);
    check("frz_cnt", stall_cnt, 4);
    check("frz_fwd_a", fwd_a_sel, 2);

    // async reset mid-stall
    cyc(1, 0, 0, 0, 0, 13, 1, 1, 0);
    cyc(1, 13, 1, 0, 0, 14, 1, 0, 0);
    check("mid_allow0", allow_in, 0);
    rst = 1'b1;
    #1;
    check("arst_allow", allow_in, 1);
    check("arst_bubble", ex_bubble, 0);
    check("arst_cnt", stall_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 13, 1, 0, 0, 14, 1, 0, 0);
    check("post_rst_allow", allow_in, 1);

    // counter saturation
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle();
    check("sat_cnt", stall_cnt, 15);
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
